// File: rtl/xts_tweak_sequencer_pkg.sv
// Shared definitions for the XTS tweak sequencer.
//   BLOCK_W  : tweak/block width, tied to GF(2^128)
//   GF_POLY  : reduction constant for multiply-by-alpha
//   state_t  : sequencer FSM states
//   gf_dbl() : multiply a tweak by alpha (x) in GF(2^128)
package xts_tweak_sequencer_pkg;

  localparam int BLOCK_W = 128;
  localparam logic [BLOCK_W-1:0] GF_POLY = 128'h87;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYREQ = 3'd1,
    ST_STREAM = 3'd2,
    ST_SWAP   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // The tweak is treated as a plain 128-bit integer: shift left one bit and
  // fold the carried-out MSB back in with the field polynomial.
  function automatic logic [BLOCK_W-1:0] gf_dbl(input logic [BLOCK_W-1:0] t);
    return {t[BLOCK_W-2:0], 1'b0} ^ (t[BLOCK_W-1] ? GF_POLY : '0);
  endfunction

endpackage

// File: rtl/xts_tweak_sequencer_if.sv
// Bundle of all command, AES-request and tweak-stream signals of the
// tweak sequencer.
//   master : the sequencer side (drives t0_req/t0_data, the tweak stream and
//            status busy/done/err; receives commands, AES result, tw_ready)
//   slave  : the environment side (mirror directions)
interface xts_tweak_sequencer_if
  import xts_tweak_sequencer_pkg::*;
#(
  parameter int CNT_W = 6
) ();

  // command
  logic               start;
  logic [BLOCK_W-1:0] sector_num;
  logic [CNT_W-1:0]   nblocks;
  logic               partial;
  logic               decrypt;
  logic               abort;
  // AES K2 request
  logic               t0_req;
  logic [BLOCK_W-1:0] t0_data;
  logic               t0_ack;
  logic [BLOCK_W-1:0] t0_result;
  // tweak stream
  logic               tw_valid;
  logic               tw_ready;
  logic [BLOCK_W-1:0] tw_data;
  logic [CNT_W-1:0]   tw_idx;
  logic               tw_last;
  // status
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    input  start, sector_num, nblocks, partial, decrypt, abort,
    input  t0_ack, t0_result, tw_ready,
    output t0_req, t0_data, tw_valid, tw_data, tw_idx, tw_last,
    output busy, done, err
  );

  modport slave (
    output start, sector_num, nblocks, partial, decrypt, abort,
    output t0_ack, t0_result, tw_ready,
    input  t0_req, t0_data, tw_valid, tw_data, tw_idx, tw_last,
    input  busy, done, err
  );

endinterface

// File: rtl/xts_tweak_sequencer.sv
// XTS tweak sequencer for one data unit.
// Requests T0 = E_K2(sector_num) from the AES core, then streams
// T0, dbl(T0), ... one tweak per accepted block. When decrypting a unit whose
// last block is partial, the final two tweaks are presented swapped
// (T[n-1] at index n-2, then T[n-2] at index n-1).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : xts_tweak_sequencer_if master modport (commands, AES handshake,
//          tweak stream, busy/done/err status)
module xts_tweak_sequencer
  import xts_tweak_sequencer_pkg::*;
#(
  parameter int CNT_W = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  xts_tweak_sequencer_if.master        bus
);

  state_t             state_reg;
  logic [BLOCK_W-1:0] sector_reg;
  logic [BLOCK_W-1:0] cur_reg;      // T[idx] in STREAM; T[n-2] in SWAP
  logic [CNT_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   nblk_reg;
  logic               part_reg;
  logic               dec_reg;
  logic               t0_req_reg;
  logic               tw_valid_reg;
  logic [BLOCK_W-1:0] tw_data_reg;
  logic [CNT_W-1:0]   tw_idx_reg;
  logic               tw_last_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  logic               swap_en;
  logic [CNT_W-1:0]   last_idx;
  logic [CNT_W-1:0]   swap_idx;
  logic [CNT_W-1:0]   idx_inc;
  logic               accept;
  logic [BLOCK_W-1:0] cur_dbl;
  logic [BLOCK_W-1:0] ack_data;
  logic [BLOCK_W-1:0] next_data;

  assign swap_en  = dec_reg & part_reg;
  assign last_idx = nblk_reg - CNT_W'(1);
  // Only meaningful when swap_en; a partial unit always has nblocks >= 2.
  assign swap_idx = nblk_reg - CNT_W'(2);
  assign idx_inc  = idx_reg + CNT_W'(1);
  assign accept   = tw_valid_reg & bus.tw_ready;
  assign cur_dbl  = gf_dbl(cur_reg);

  // Tweak presented for index 0 straight from the AES result; a two-block
  // decrypt-CTS unit swaps already at index 0.
  assign ack_data  = (swap_en && (swap_idx == '0)) ? gf_dbl(bus.t0_result) : bus.t0_result;
  // Tweak presented for idx+1; at the swap point the look-ahead T[n-1] goes out.
  assign next_data = (swap_en && (idx_inc == swap_idx)) ? gf_dbl(cur_dbl) : cur_dbl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      sector_reg   <= '0;
      cur_reg      <= '0;
      idx_reg      <= '0;
      nblk_reg     <= '0;
      part_reg     <= 1'b0;
      dec_reg      <= 1'b0;
      t0_req_reg   <= 1'b0;
      tw_valid_reg <= 1'b0;
      tw_data_reg  <= '0;
      tw_idx_reg   <= '0;
      tw_last_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (bus.abort) begin
        state_reg    <= ST_IDLE;
        t0_req_reg   <= 1'b0;
        tw_valid_reg <= 1'b0;
        tw_last_reg  <= 1'b0;
        busy_reg     <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.start) begin
              if (bus.nblocks == '0) begin
                // Empty unit: complete without touching the AES core.
                sector_reg <= bus.sector_num;
                nblk_reg   <= bus.nblocks;
                part_reg   <= bus.partial;
                dec_reg    <= bus.decrypt;
                done_reg   <= 1'b1;
                state_reg  <= ST_DONE;
              end else if (bus.partial && (bus.nblocks < CNT_W'(2))) begin
                // Ciphertext stealing needs a full block before the partial one.
                err_reg <= 1'b1;
              end else begin
                sector_reg <= bus.sector_num;
                nblk_reg   <= bus.nblocks;
                part_reg   <= bus.partial;
                dec_reg    <= bus.decrypt;
                t0_req_reg <= 1'b1;
                busy_reg   <= 1'b1;
                state_reg  <= ST_KEYREQ;
              end
            end
          end

          ST_KEYREQ: begin
            if (bus.t0_ack) begin
              cur_reg      <= bus.t0_result;
              idx_reg      <= '0;
              tw_data_reg  <= ack_data;
              tw_idx_reg   <= '0;
              tw_last_reg  <= (last_idx == '0);
              tw_valid_reg <= 1'b1;
              t0_req_reg   <= 1'b0;
              state_reg    <= ST_STREAM;
            end
          end

          ST_STREAM: begin
            if (accept) begin
              if (tw_last_reg) begin
                tw_valid_reg <= 1'b0;
                tw_last_reg  <= 1'b0;
                busy_reg     <= 1'b0;
                done_reg     <= 1'b1;
                state_reg    <= ST_DONE;
              end else if (swap_en && (idx_reg == swap_idx)) begin
                // cur still holds T[n-2]; it is the tweak for the final block.
                tw_data_reg <= cur_reg;
                tw_idx_reg  <= last_idx;
                tw_last_reg <= 1'b1;
                state_reg   <= ST_SWAP;
              end else begin
                cur_reg     <= cur_dbl;
                idx_reg     <= idx_inc;
                tw_data_reg <= next_data;
                tw_idx_reg  <= idx_inc;
                tw_last_reg <= (idx_inc == last_idx);
              end
            end
          end

          ST_SWAP: begin
            if (accept) begin
              tw_valid_reg <= 1'b0;
              tw_last_reg  <= 1'b0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
              state_reg    <= ST_DONE;
            end
          end

          ST_DONE: begin
            state_reg <= ST_IDLE;
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.t0_req   = t0_req_reg;
  assign bus.t0_data  = sector_reg;
  assign bus.tw_valid = tw_valid_reg;
  assign bus.tw_data  = tw_data_reg;
  assign bus.tw_idx   = tw_idx_reg;
  assign bus.tw_last  = tw_last_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_xts_tweak_sequencer.sv
// Self-checking bench for xts_tweak_sequencer: expected tweaks are queued when
// a unit is started and compared against every cycle tw_valid is high.
module tb_xts_tweak_sequencer;
  import xts_tweak_sequencer_pkg::*;

  localparam int CNT_W = 6;

  localparam logic [127:0] K_T0 = 128'h555555555555555555555555555555d3;
  localparam logic [127:0] K_T1 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaba6;
  localparam logic [127:0] K_T2 = 128'h5555555555555555555555555555_57cb;
  localparam logic [127:0] K_T3 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaa_af96;

  typedef struct packed {
    logic [127:0]     data;
    logic [CNT_W-1:0] idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xts_tweak_sequencer_if #(.CNT_W(CNT_W)) bus ();

  xts_tweak_sequencer #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   req_cnt  = 0;
  int   busy_cnt = 0;
  int   acc_cnt  = 0;
  int   vcyc_cnt = 0;
  int   acc_cyc[int];
  bit   mon_en     = 1'b0;
  bit   auto_ack   = 1'b1;
  bit   rand_ready = 1'b0;
  int   ack_delay  = 1;
  int   late_req   = 0;
  logic [127:0] exp_sector = '0;
  logic [127:0] ack_t0     = '0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [127:0] model_dbl(input logic [127:0] t);
    logic [127:0] r;
    r = t << 1;
    if (t[127]) r = r ^ 128'h87;
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (!rst && mon_en) begin
      if (bus.done)   done_cnt++;
      if (bus.err)    err_cnt++;
      if (bus.t0_req) req_cnt++;
      if (bus.busy)   busy_cnt++;
      if (bus.tw_valid) begin
        vcyc_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_tweak", {121'b0, bus.tw_idx, bus.tw_last}, '1);
        end else begin
          mon_e = exp_q[0];
          check_val("tw_data", bus.tw_data, mon_e.data);
          check_val("tw_idx", 128'(bus.tw_idx), 128'(mon_e.idx));
          check_val("tw_last", 128'(bus.tw_last), 128'(mon_e.last));
          if (bus.tw_ready) begin
            void'(exp_q.pop_front());
            acc_cyc[acc_cnt] = cyc;
            acc_cnt++;
            $display("tweak idx=%0d last=%0b data=%h", bus.tw_idx, bus.tw_last, bus.tw_data);
          end
        end
      end
    end
  end

  // ---------------- AES K2 model ----------------
  initial begin
    int late_done;
    late_done = 0;
    bus.t0_ack    = 1'b0;
    bus.t0_result = '0;
    forever begin
      @(negedge clk);
      if (late_req != late_done) begin
        late_done = late_req;
        @(posedge clk); #1;
        bus.t0_ack = 1'b1; bus.t0_result = ack_t0;
        @(posedge clk); #1;
        bus.t0_ack = 1'b0;
      end else if (auto_ack && !rst && bus.t0_req) begin
        check_val("t0_data", bus.t0_data, exp_sector);
        repeat (ack_delay) @(posedge clk);
        #1;
        bus.t0_ack = 1'b1; bus.t0_result = ack_t0;
        @(posedge clk); #1;
        bus.t0_ack = 1'b0;
      end
    end
  end

  // ---------------- data-path ready ----------------
  initial begin
    bus.tw_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.tw_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_expected(input logic [127:0] t0, input int nb, input bit part, input bit dec);
    logic [127:0] t [64];
    t[0] = t0;
    for (int i = 1; i < nb; i++) t[i] = model_dbl(t[i-1]);
    for (int i = 0; i < nb; i++) begin
      if (dec && part && i == nb - 2) begin
        exp_q.push_back('{data: t[nb-1], idx: CNT_W'(i), last: 1'b0});
        exp_q.push_back('{data: t[nb-2], idx: CNT_W'(nb-1), last: 1'b1});
        break;
      end
      exp_q.push_back('{data: t[i], idx: CNT_W'(i), last: (i == nb - 1)});
    end
  endtask

  task automatic pulse_start(input logic [127:0] sec, input int nb, input bit part, input bit dec);
    @(posedge clk); #1;
    bus.sector_num = sec;
    bus.nblocks    = CNT_W'(nb);
    bus.partial    = part;
    bus.decrypt    = dec;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) begin seen = 1'b1; break; end
    end
    check_val(tag, 128'(seen), 128'd1);
  endtask

  // Expected tweaks must already be queued.
  task automatic run_unit(input string tag, input logic [127:0] sec, input int nb,
                          input bit part, input bit dec, input logic [127:0] t0);
    int d0;
    d0 = done_cnt;
    exp_sector = sec;
    ack_t0     = t0;
    pulse_start(sec, nb, part, dec);
    wait_done({tag, "_done_seen"}, 400);
    @(negedge clk);
    check_val({tag, "_done_once"}, 128'(done_cnt - d0), 128'd1);
    check_val({tag, "_done_pulse"}, 128'(bus.done), 128'd0);
    check_val({tag, "_q_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- main ----------------
  initial begin
    int a0, r0, d0, e0, b0, v0;
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.sector_num = '0; bus.nblocks = '0;
    bus.partial = 1'b0; bus.decrypt = 1'b0; bus.abort = 1'b0;
    #12;
    check_val("rst_t0_req", 128'(bus.t0_req), 0);
    check_val("rst_tw_valid", 128'(bus.tw_valid), 0);
    check_val("rst_tw_data", bus.tw_data, 0);
    check_val("rst_busy_done_err", {125'b0, bus.busy, bus.done, bus.err}, 0);
    check_val("rst_tw_last_idx", {121'b0, bus.tw_idx, bus.tw_last}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: encrypt, 4 blocks, continuous ready
    exp_q.push_back('{data: K_T0, idx: 6'd0, last: 1'b0});
    exp_q.push_back('{data: K_T1, idx: 6'd1, last: 1'b0});
    exp_q.push_back('{data: K_T2, idx: 6'd2, last: 1'b0});
    exp_q.push_back('{data: K_T3, idx: 6'd3, last: 1'b1});
    a0 = acc_cnt;
    run_unit("t1", 128'h1234, 4, 1'b0, 1'b0, K_T0);
    check_val("t1_accepts", 128'(acc_cnt - a0), 128'd4);
    check_val("t1_no_bubble", 128'(acc_cyc[a0+3] - acc_cyc[a0]), 128'd3);

    // 2: decrypt with CTS, 3 blocks
    exp_q.push_back('{data: K_T0, idx: 6'd0, last: 1'b0});
    exp_q.push_back('{data: K_T2, idx: 6'd1, last: 1'b0});
    exp_q.push_back('{data: K_T1, idx: 6'd2, last: 1'b1});
    run_unit("t2", 128'h77, 3, 1'b1, 1'b1, K_T0);

    // 3: random back-pressure and other unit shapes
    rand_ready = 1'b1;
    push_expected(K_T0, 4, 1'b0, 1'b0);
    run_unit("t3_enc4", 128'h1234, 4, 1'b0, 1'b0, K_T0);
    push_expected(K_T3, 2, 1'b1, 1'b1);
    run_unit("t3_cts2", 128'hbeef, 2, 1'b1, 1'b1, K_T3);
    push_expected(K_T1, 5, 1'b0, 1'b1);
    run_unit("t3_dec5", 128'h5, 5, 1'b0, 1'b1, K_T1);
    push_expected(K_T2, 5, 1'b1, 1'b0);
    run_unit("t3_encp5", 128'h6, 5, 1'b1, 1'b0, K_T2);
    push_expected({$urandom, $urandom, $urandom, $urandom}, 17, 1'b1, 1'b1);
    run_unit("t3_cts17", 128'h17, 17, 1'b1, 1'b1, exp_q[0].data);
    push_expected({$urandom, $urandom, $urandom, $urandom}, 63, 1'b0, 1'b0);
    run_unit("t3_max63", 128'h3f, 63, 1'b0, 1'b0, exp_q[0].data);
    rand_ready = 1'b0;

    // 4: empty unit, start in DONE ignored, rejected partial start
    r0 = req_cnt; b0 = busy_cnt;
    pulse_start(128'h9, 0, 1'b0, 1'b0);
    wait_done("t4_empty_done", 10);
    bus.nblocks = 6'd4; bus.start = 1'b1;   // DONE cycle: must be ignored
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("t4_no_t0_req", 128'(req_cnt - r0), 0);
    check_val("t4_no_busy", 128'(busy_cnt - b0), 0);
    e0 = err_cnt;
    pulse_start(128'ha, 1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_val("t4_err_pulse", 128'(err_cnt - e0), 128'd1);
    check_val("t4_err_no_busy", 128'(busy_cnt - b0), 0);

    // 5: abort in KEYREQ followed by a late ack
    auto_ack = 1'b0;
    d0 = done_cnt; v0 = vcyc_cnt;
    pulse_start(128'hab, 4, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.t0_req) begin seen = 1'b1; break; end
    end
    check_val("t5_req_seen", 128'(seen), 128'd1);
    @(posedge clk); #1; bus.abort = 1'b1;
    @(posedge clk); #1; bus.abort = 1'b0;
    @(negedge clk);
    check_val("t5_req_dropped", 128'(bus.t0_req), 0);
    check_val("t5_busy_dropped", 128'(bus.busy), 0);
    ack_t0 = K_T1;
    late_req++;
    repeat (6) @(negedge clk);
    check_val("t5_no_valid", 128'(vcyc_cnt - v0), 0);
    check_val("t5_no_done", 128'(done_cnt - d0), 0);
    auto_ack = 1'b1;
    push_expected(K_T1, 3, 1'b0, 1'b0);
    run_unit("t5_fresh", 128'hcd, 3, 1'b0, 1'b0, K_T1);

    // 6: async reset mid-stream, then start while busy
    rand_ready = 1'b1;
    a0 = acc_cnt;
    push_expected(K_T0, 12, 1'b0, 1'b0);
    exp_sector = 128'hee; ack_t0 = K_T0;
    pulse_start(128'hee, 12, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 3) begin seen = 1'b1; break; end
    end
    check_val("t6_streaming", 128'(seen), 128'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_val("t6_rst_valid", 128'(bus.tw_valid), 0);
    check_val("t6_rst_data", bus.tw_data, 0);
    check_val("t6_rst_ctl", {123'b0, bus.t0_req, bus.tw_last, bus.busy, bus.done, bus.err}, 0);
    check_val("t6_rst_t0_data", bus.t0_data, 0);
    exp_q.delete();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    ack_delay = 3;
    a0 = acc_cnt; d0 = done_cnt;
    push_expected(K_T2, 3, 1'b1, 1'b1);
    exp_sector = 128'h111; ack_t0 = K_T2;
    pulse_start(128'h111, 3, 1'b1, 1'b1);
    pulse_start(128'h222, 5, 1'b0, 1'b0);   // ignored: unit already busy
    wait_done("t6_busy_done", 100);
    @(negedge clk);
    check_val("t6_busy_accepts", 128'(acc_cnt - a0), 128'd3);
    check_val("t6_busy_q_empty", 128'(exp_q.size()), 0);
    check_val("t6_busy_one_done", 128'(done_cnt - d0), 128'd1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
